fetch_buffer: RTL and testbench

//   Decoupling FIFO between the instruction-cache fetch register and the 4-wide decode stage.

---
 rtl/core_pkg.sv | 18 +
 rtl/fb_mem.sv | 39 +++
 rtl/fetch_buffer.sv | 95 +++++++++
 tb/tb_fetch_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared front-end constants and the fetch slot-valid mask helper.
package core_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int WIDTH_INSTR = 32;
  localparam int WIDTH_PC    = 32;

  // Slot k of a packet is live iff it sits at or after the fetch PC's word offset.
  function automatic logic [FETCH_WIDTH-1:0] imask_from_pc(input logic [1:0] slot);
    logic [FETCH_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      m[k] = (k >= int'(slot));
    end
    return m;
  endfunction

endpackage

// File: rtl/fb_mem.sv
// Fetch-buffer storage: register array, one synchronous write port and one asynchronous read port.
module fb_mem
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FETCH_WIDTH * WIDTH_INSTR + WIDTH_PC + FETCH_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_we) begin
      mem_d[i_waddr] = i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-packet FIFO between the I-cache fetch register and the 4-wide decode stage.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int WIDTH_PC    = 32,
  parameter int WIDTH_INSTR = 32,
  parameter int DEPTH       = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_flush,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [FETCH_WIDTH*WIDTH_INSTR-1:0] i_data4x,
  input  logic [WIDTH_PC-1:0]                i_pc,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [FETCH_WIDTH*WIDTH_INSTR-1:0] o_data4x,
  output logic [WIDTH_PC-1:0]                o_pc,
  output logic [FETCH_WIDTH-1:0]             o_imask,
  output logic [$clog2(DEPTH):0]             o_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DATA_W  = FETCH_WIDTH * WIDTH_INSTR;
  localparam int ENTRY_W = DATA_W + WIDTH_PC + FETCH_WIDTH;

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [FETCH_WIDTH-1:0] imask_in;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign o_ready = (count_q != CNT_W'(DEPTH));
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = o_valid & i_ready & ~i_flush;

  assign imask_in = imask_from_pc(i_pc[3:2]);
  assign wdata    = {imask_in, i_pc, i_data4x};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      // Push and pop together leave occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (push),
    .i_waddr (tail_q),
    .i_wdata (wdata),
    .i_raddr (head_q),
    .o_rdata (rdata)
  );

  assign o_data4x = rdata[DATA_W-1:0];
  assign o_pc     = rdata[DATA_W +: WIDTH_PC];
  assign o_imask  = rdata[DATA_W+WIDTH_PC +: FETCH_WIDTH];

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed packets, monitor pops expected head entries.
module tb_fetch_buffer;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] data;
    logic [3:0]   mask;
  } ent_t;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [127:0] i_data4x = '0;
  logic [31:0]  i_pc = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [127:0] o_data4x;
  logic [31:0]  o_pc;
  logic [3:0]   o_imask;
  logic [3:0]   o_count;

  int   n_assert = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  bit   after_rst = 1'b0;
  ent_t exp_q[$];

  always #5 i_clk = ~i_clk;

  fetch_buffer #(.WIDTH_PC(32), .WIDTH_INSTR(32), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data4x(i_data4x), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_data4x(o_data4x), .o_pc(o_pc), .o_imask(o_imask), .o_count(o_count)
  );

  function automatic logic [3:0] exp_mask(input logic [31:0] pc);
    case (pc[3:2])
      2'd0:    return 4'b1111;
      2'd1:    return 4'b1110;
      2'd2:    return 4'b1100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [127:0] mk_data(input logic [31:0] pc);
    return {pc ^ 32'h3333_0003, pc ^ 32'h2222_0002, pc ^ 32'h1111_0001, pc ^ 32'hC0DE_0000};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_pkt(input logic [31:0] pc);
    i_pc     = pc;
    i_data4x = mk_data(pc);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) cyc();
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    i_ready = 1'b0;
  endtask

  // Monitor: state checks against the bench model, then model update for this edge.
  always @(negedge i_clk) begin
    if (mon_en) begin
      int  sz;
      bit  do_push, do_pop;
      sz = exp_q.size();
      chk("count", 128'(o_count), 128'(sz));
      chk("valid", 128'(o_valid), 128'(sz != 0));
      chk("ready", 128'(o_ready), 128'(sz != DEPTH));
      if (sz != 0) begin
        chk("head_pc",   128'(o_pc),    128'(exp_q[0].pc));
        chk("head_data", o_data4x,      exp_q[0].data);
        chk("head_mask", 128'(o_imask), 128'(exp_q[0].mask));
      end else if (after_rst) begin
        chk("rst_pc",   128'(o_pc),    128'd0);
        chk("rst_data", o_data4x,      128'd0);
        chk("rst_mask", 128'(o_imask), 128'd0);
      end
      if (i_rst || i_flush) begin
        exp_q.delete();
        after_rst = i_rst;
      end else begin
        do_pop  = (sz != 0) && i_ready;
        do_push = i_valid && (sz != DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          ent_t e;
          e.pc   = i_pc;
          e.data = i_data4x;
          e.mask = exp_mask(i_pc);
          exp_q.push_back(e);
          after_rst = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held two cycles with a packet offered
    i_rst = 1'b1;
    i_valid = 1'b1;
    set_pkt(32'h0000_0040);
    cyc();
    mon_en = 1'b1;
    cyc();
    chk("t1_valid", 128'(o_valid),  128'd0);
    chk("t1_ready", 128'(o_ready),  128'd1);
    chk("t1_count", 128'(o_count),  128'd0);
    chk("t1_data",  o_data4x,       128'd0);
    chk("t1_pc",    128'(o_pc),     128'd0);
    chk("t1_mask",  128'(o_imask),  128'd0);
    i_rst = 1'b0;
    i_valid = 1'b0;
    cyc();

    // 2: alignment masks
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_pkt(32'h100 + 32'(i * 4));
      cyc();
    end
    i_valid = 1'b0;
    chk("t2_count", 128'(o_count), 128'd4);
    chk("t2_mask0", 128'(o_imask), 128'(4'b1111));
    drain();

    // 3: fill to full, ninth packet retries until a pop frees a slot
    i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_pkt(32'(i * 16));
      cyc();
    end
    chk("t3_full_ready", 128'(o_ready), 128'd0);
    set_pkt(32'h80);
    cyc();
    cyc();
    chk("t3_full_count", 128'(o_count), 128'd8);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    cyc();
    i_valid = 1'b0;
    chk("t3_refill", 128'(o_count), 128'd8);
    drain();

    // 4: streaming push+pop, pointers wrap twice
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_pkt(32'h1000 + 32'(i * 16));
      cyc();
    end
    chk("t4_count", 128'(o_count), 128'd1);
    chk("t4_pc",    128'(o_pc),    128'h1130);
    drain();

    // 5: flush with push and pop offered
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_pkt(32'h2000 + 32'(i * 4));
      cyc();
    end
    i_flush = 1'b1;
    i_ready = 1'b1;
    set_pkt(32'h2100);
    cyc();
    i_flush = 1'b0;
    i_ready = 1'b0;
    chk("t5_count", 128'(o_count), 128'd0);
    chk("t5_valid", 128'(o_valid), 128'd0);
    set_pkt(32'h500);
    cyc();
    i_valid = 1'b0;
    chk("t5_newhead", 128'(o_pc), 128'h500);
    drain();

    // 6: reset mid-stream, then reset together with flush
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pkt(32'h3008 + 32'(i * 16));
      cyc();
    end
    i_rst = 1'b1;
    i_ready = 1'b1;
    cyc();
    i_rst = 1'b0;
    i_ready = 1'b0;
    chk("t6_count", 128'(o_count), 128'd0);
    chk("t6_data",  o_data4x,      128'd0);
    for (int i = 0; i < 2; i++) begin
      set_pkt(32'h4004 + 32'(i * 16));
      cyc();
    end
    i_rst = 1'b1;
    i_flush = 1'b1;
    cyc();
    i_rst = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("t6_both_count", 128'(o_count), 128'd0);
    chk("t6_both_data",  o_data4x,      128'd0);
    cyc();
    drain();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
